// File: rtl/huffman_decode_pkg.sv
// Shared widths, state encoding and symbol values for the Huffman stream decoder.
package huffman_decode_pkg;

    localparam int unsigned P_WIDTH   = 32;
    localparam int unsigned BUF_WIDTH = 2 * P_WIDTH;
    localparam int unsigned C_WIDTH   = 4;
    localparam int unsigned VLC_WIDTH = 5;
    localparam int unsigned CNT_WIDTH = 7;
    localparam int unsigned LEN_WIDTH = 3;

    typedef logic [C_WIDTH-1:0]   sym_t;
    typedef logic [LEN_WIDTH-1:0] len_t;

    localparam sym_t SYM_A   = 4'd0;
    localparam sym_t SYM_B   = 4'd1;
    localparam sym_t SYM_C   = 4'd2;
    localparam sym_t SYM_D   = 4'd3;
    localparam sym_t SYM_E   = 4'd4;
    localparam sym_t SYM_F   = 4'd5;
    localparam sym_t SYM_G   = 4'd6;
    localparam sym_t SYM_H   = 4'd7;
    localparam sym_t SYM_EOS = 4'd8;
    localparam sym_t EOM_SYM = SYM_EOS;

    localparam len_t LEN_2 = 3'd2;
    localparam len_t LEN_3 = 3'd3;
    localparam len_t LEN_4 = 3'd4;
    localparam len_t LEN_5 = 3'd5;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_LOAD   = 2'd1,
        ST_DECODE = 2'd2
    } state_e;

endpackage

// File: rtl/huffman_decode_if.sv
// Upstream FWFT FIFO read port and downstream FIFO write port of the decoder.
interface huffman_decode_if;
    import huffman_decode_pkg::*;

    logic [P_WIDTH-1:0] idata;
    logic               rdy;
    logic               pop;
    logic [C_WIDTH-1:0] code;
    logic               push;
    logic               not_full;

    modport master (
        input  idata, rdy, not_full,
        output pop, code, push
    );

    modport slave (
        output idata, rdy, not_full,
        input  pop, code, push
    );

endinterface

// File: rtl/huffman_decode_code_match.sv
// Combinational prefix match of the top buffer bits against the code table.
module huffman_code_match
    import huffman_decode_pkg::*;
(
    input  logic [VLC_WIDTH-1:0] bits_i,
    output sym_t                 sym_c_o,
    output len_t                 len_c_o
);

    // Bits below the valid count are zero, so a short tail never matches a longer code.
    always_comb begin
        sym_c_o = SYM_E;
        len_c_o = LEN_2;
        casez (bits_i)
            5'b00???: begin sym_c_o = SYM_E;   len_c_o = LEN_2; end
            5'b01???: begin sym_c_o = SYM_H;   len_c_o = LEN_2; end
            5'b100??: begin sym_c_o = SYM_A;   len_c_o = LEN_3; end
            5'b101??: begin sym_c_o = SYM_D;   len_c_o = LEN_3; end
            5'b1100?: begin sym_c_o = SYM_C;   len_c_o = LEN_4; end
            5'b1101?: begin sym_c_o = SYM_F;   len_c_o = LEN_4; end
            5'b1110?: begin sym_c_o = SYM_G;   len_c_o = LEN_4; end
            5'b11110: begin sym_c_o = SYM_B;   len_c_o = LEN_5; end
            5'b11111: begin sym_c_o = SYM_EOS; len_c_o = LEN_5; end
            default:  begin sym_c_o = SYM_E;   len_c_o = LEN_2; end
        endcase
    end

endmodule

// File: rtl/huffman_decode.sv
// Pops packed words from an FWFT FIFO, extracts MSB-first variable-length codes
// across word boundaries and pushes one decoded symbol per cycle downstream.
module huffman_decode
    import huffman_decode_pkg::*;
(
    input logic              clk,
    input logic              reset,
    huffman_decode_if.master bus
);

    state_e                 state_q, state_d;
    logic [BUF_WIDTH-1:0]   buf_q,   buf_d;
    logic [CNT_WIDTH-1:0]   cnt_q,   cnt_d;
    logic                   pop_q,   pop_d;
    logic                   push_q,  push_d;
    sym_t                   code_q,  code_d;

    sym_t                   sym_c;
    len_t                   len_c;

    huffman_code_match u_match (
        .bits_i  (buf_q[BUF_WIDTH-1 -: VLC_WIDTH]),
        .sym_c_o (sym_c),
        .len_c_o (len_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            buf_q   <= '0;
            cnt_q   <= '0;
            pop_q   <= 1'b0;
            push_q  <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        pop_d   = 1'b0;
        push_d  = 1'b0;
        code_d  = code_q;
        case (state_q)
            ST_FETCH: begin
                if (bus.rdy) begin
                    pop_d   = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Append the popped word directly below the bits still held.
                buf_d   = buf_q | ({bus.idata, {P_WIDTH{1'b0}}} >> cnt_q);
                cnt_d   = cnt_q + CNT_WIDTH'(P_WIDTH);
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (cnt_q < CNT_WIDTH'(len_c)) begin
                    state_d = ST_FETCH;
                end else if (bus.not_full) begin
                    push_d = 1'b1;
                    code_d = sym_c;
                    if (sym_c == EOM_SYM) begin
                        // Padding after end-of-stream is dropped; next word starts a new message.
                        buf_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_FETCH;
                    end else begin
                        buf_d = buf_q << len_c;
                        cnt_d = cnt_q - CNT_WIDTH'(len_c);
                    end
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    assign bus.pop  = pop_q;
    assign bus.push = push_q;
    assign bus.code = code_q;

endmodule

// File: tb/tb_huffman_decode.sv
// Scoreboard bench: an encoder model builds word streams and expected symbols,
// a negedge monitor models the FIFOs and checks every push and pop.
module tb_huffman_decode;

    logic clk = 1'b0;
    logic reset;

    huffman_decode_if bus();

    huffman_decode dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] wq[$];
    int          expq[$];

    int cyc = 0, n_pops = 0, n_push = 0;
    int pop_cyc = 0, rdy_rise_cyc = 0, first_push_cyc = 0, last_push_cyc = 0;
    bit mark = 1'b0, pop_pending = 1'b0, nf_prev = 1'b1, rdy_prev = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    endtask

    // Code table in transmit order.
    function automatic int code_len(input int s);
        case (s)
            0: return 3;  1: return 5;  2: return 4;  3: return 3;
            4: return 2;  5: return 4;  6: return 4;  7: return 2;
            default: return 5;
        endcase
    endfunction

    function automatic int code_val(input int s);
        case (s)
            0: return 'b100;  1: return 'b11110; 2: return 'b1100; 3: return 'b101;
            4: return 'b00;   5: return 'b1101;  6: return 'b1110; 7: return 'b01;
            default: return 'b11111;
        endcase
    endfunction

    // Encode a message plus end-of-stream, zero-pad into 32-bit words.
    task automatic send_msg(input int syms[$]);
        bit          bq[$];
        int          v, l;
        logic [31:0] w;
        syms.push_back(8);
        foreach (syms[i]) begin
            l = code_len(syms[i]);
            v = code_val(syms[i]);
            for (int b = l - 1; b >= 0; b--) bq.push_back(v[b]);
            expq.push_back(syms[i]);
        end
        while (bq.size() != 0) begin
            w = '0;
            for (int k = 31; k >= 0; k--) if (bq.size() != 0) w[k] = bq.pop_front();
            wq.push_back(w);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_basic();
        expq.push_back(0); expq.push_back(4); expq.push_back(7); expq.push_back(8);
    endtask

    task automatic exp_straddle();
        repeat (7) expq.push_back(1);
        expq.push_back(8);
    endtask

    task automatic wait_drain(input string name);
        int c = 0;
        while ((expq.size() != 0 || wq.size() != 0) && c < 2000) begin
            tick();
            c++;
        end
        check({name, "_drained"}, int'(expq.size()), 0);
        repeat (4) tick();
    endtask

    task automatic wait_pop(input int base, input string name);
        int c = 0;
        while (n_pops == base && c < 100) begin
            tick();
            c++;
        end
        check({name, "_pop_seen"}, int'(n_pops > base), 1);
    endtask

    // FIFO models and output monitor, all at the inactive edge.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            wq.delete();
            expq.delete();
            pop_pending = 1'b0;
        end else begin
            if (bus.pop) begin
                check("pop_needs_rdy", int'(bus.rdy), 1);
                check("pop_single_pulse", int'(pop_pending), 0);
                n_pops++;
                pop_cyc = cyc;
            end
            if (bus.push) begin
                n_push++;
                last_push_cyc = cyc;
                if (mark) begin
                    first_push_cyc = cyc;
                    mark = 1'b0;
                end
                check("push_needs_not_full", int'(nf_prev), 1);
                check("push_expected", int'(expq.size() != 0), 1);
                if (expq.size() != 0) check("code", int'(bus.code), expq.pop_front());
            end
            if (pop_pending && wq.size() != 0) void'(wq.pop_front());
            pop_pending = bus.pop;
        end
        nf_prev   = bus.not_full;
        bus.rdy   = (wq.size() != 0);
        bus.idata = (wq.size() != 0) ? wq[0] : 32'h0;
        if (bus.rdy && !rdy_prev) rdy_rise_cyc = cyc;
        rdy_prev = bus.rdy;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int bp, bs, c, left;
        int syms[$];

        reset        = 1'b1;
        bus.not_full = 1'b1;
        tick();
        tick();
        check("reset_pop", int'(bus.pop), 0);
        check("reset_push", int'(bus.push), 0);
        check("reset_code", int'(bus.code), 0);
        reset = 1'b0;

        // Basic message
        bp = n_pops; bs = n_push; mark = 1'b1;
        wq.push_back(32'h83F00000);
        exp_basic();
        wait_drain("basic");
        repeat (10) tick();
        check("basic_pops", n_pops - bp, 1);
        check("basic_pushes", n_push - bs, 4);
        check("basic_latency", first_push_cyc - pop_cyc, 2);
        check("basic_burst", last_push_cyc - first_push_cyc, 3);

        // Code straddling a word boundary
        bp = n_pops; bs = n_push;
        wq.push_back(32'hF7BDEF7B);
        wq.push_back(32'hDF000000);
        exp_straddle();
        wait_drain("straddle");
        check("straddle_pops", n_pops - bp, 2);
        check("straddle_pushes", n_push - bs, 8);

        // Back-pressure
        bp = n_pops; bs = n_push;
        bus.not_full = 1'b0;
        wq.push_back(32'h83F00000);
        exp_basic();
        wait_pop(bp, "bp");
        repeat (5) tick();
        check("bp_hold_pushes", n_push - bs, 0);
        mark = 1'b1;
        bus.not_full = 1'b1;
        wait_drain("bp");
        check("bp_pushes", n_push - bs, 4);
        check("bp_burst", last_push_cyc - first_push_cyc, 3);

        // Back-to-back messages with padding
        bp = n_pops; bs = n_push;
        wq.push_back(32'h83F00000);
        wq.push_back(32'h83F00000);
        exp_basic();
        exp_basic();
        wait_drain("b2b");
        check("b2b_pops", n_pops - bp, 2);
        check("b2b_pushes", n_push - bs, 8);

        // Starved input
        bp = n_pops; bs = n_push;
        repeat (20) tick();
        check("starve_pops", n_pops - bp, 0);
        check("starve_pushes", n_push - bs, 0);
        wq.push_back(32'h83F00000);
        exp_basic();
        wait_pop(bp, "starve");
        check("starve_rdy_to_pop", pop_cyc - rdy_rise_cyc, 1);
        wait_drain("starve");

        // Reset during decode
        wq.push_back(32'hF7BDEF7B);
        wq.push_back(32'hDF000000);
        exp_straddle();
        c = 0;
        while (!bus.push && c < 100) begin
            tick();
            c++;
        end
        check("rst_push_seen", int'(bus.push), 1);
        reset = 1'b1;
        #1;
        check("rst_async_push", int'(bus.push), 0);
        check("rst_async_pop", int'(bus.pop), 0);
        tick();
        tick();
        reset = 1'b0;
        bs = n_push;
        wq.push_back(32'h83F00000);
        exp_basic();
        wait_drain("post_reset");
        check("post_reset_pushes", n_push - bs, 4);

        // Randomized messages under random back-pressure
        left = 25;
        repeat (3000) begin
            tick();
            bus.not_full = ($urandom_range(0, 9) < 7);
            if (left > 0 && $urandom_range(0, 5) == 0) begin
                syms.delete();
                repeat ($urandom_range(1, 15)) syms.push_back(int'($urandom_range(0, 7)));
                send_msg(syms);
                left--;
            end
        end
        bus.not_full = 1'b1;
        wait_drain("random");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/huffman_decode.md
Name: huffman_decode

Overview:
Receiving end of the packed Huffman stream. It pops 32-bit packed words from an upstream first-word-fall-through FIFO and extracts variable-length codes MSB-first. Codes may straddle word boundaries. Each decoded 4-bit symbol is pushed into a downstream FIFO. An end-of-stream code (symbol 8) terminates the message; the remaining padding bits in the current word are discarded.

Parameters:
P_WIDTH, 32, packed input word width; buffer is 2*P_WIDTH.
C_WIDTH, 4, fixed-length symbol width.
VLC_WIDTH, 5, maximum variable-length code width.
EOM_SYM, 4'd8, symbol value of end-of-stream.

Ports:
clk  in  1  clock; all state on rising edge.
reset  in  1  asynchronous, active-high reset.
idata  in  P_WIDTH  packed word; first transmitted bit at idata[31]; valid whenever rdy=1 (FWFT).
rdy  in  1  upstream FIFO not empty.
pop  out  1  registered one-cycle pulse; consumes idata in the same cycle.
code  out  C_WIDTH  decoded symbol; valid when push=1.
push  out  1  registered one-cycle pulse; writes code downstream.
not_full  in  1  downstream FIFO can accept a write.

Behaviour:
- Code table (bits in transmit order): A0=100, B1=11110, C2=1100, D3=101, E4=00, F5=1101, G6=1110, H7=01, EOS8=11111.
- Bit buffer: buf[63:0], MSB-aligned. cnt[6:0] holds valid bits, 0..36. Bits below cnt are always 0.
- Length rule: L is derived from buf[63:59] with zero fill. 0x→2, 10x→3, 110x→4, 1110→4, 1111x→5. A code is decodable iff cnt>=L. Prefix-freeness guarantees an incomplete code never yields L<=cnt.
- Reset values: pop=0, push=0, code=0, buf=0, cnt=0, state=FETCH. Asserting reset mid-operation drops pop/push immediately and discards any partial code.
- FSM states:
  - FETCH: if rdy, pop_wc=1 and go to LOAD; otherwise hold. Fetch happens only when cnt<L, so cnt<=4.
  - LOAD: pop=1 this cycle. Set buf |= idata << (32-cnt), cnt += 32, go to DECODE.
  - DECODE:
    - cnt<L: go to FETCH.
    - cnt>=L and not_full=0: hold; no shift, no push.
    - cnt>=L and not_full=1: push_wc=1, code=symbol, buf<<=L, cnt-=L, stay in DECODE.
    - If the symbol is EOS: additionally buf=0, cnt=0, go to FETCH. Padding is dropped and the next word starts a new message.
- Latency: pop high in cycle N → first push/code high in cycle N+2. Steady-state throughput is 1 symbol/cycle while not_full=1.
- At most one pop is outstanding; pop is never asserted when rdy=0.
- Simultaneous events: rdy is ignored outside FETCH. not_full is ignored outside DECODE.
- Data in a word after EOS is never decoded. Malformed streams are undefined beyond the table; no error output.

Decomposition:
- Shared include huffman_defs.vh: symbol encodings A..H, EOS, EOM_SYM, state encodings FETCH/LOAD/DECODE, code-table constants. The encoder and decoder share these.
- One combinational sub-module, huffman_code_match: input buf top VLC_WIDTH bits; outputs symbol[C_WIDTH-1:0] and length[2:0].
- The FSM, buffer and handshakes stay in huffman_decode.

Test Plan:
- Basic message: idata=0x83F00000, rdy high for one word, not_full=1 → one pop. Pushes code 0,4,7,8 on consecutive cycles, first push 2 cycles after pop. Then FETCH with no further pop while rdy=0.
- Word-straddle: words 0xF7BDEF7B then 0xDF000000 → two pops. Seven pushes of code 1, then code 8. The seventh B spans both words.
- Back-pressure: test 1 stimulus with not_full=0 for 5 cycles after LOAD → no push while low. Codes 0,4,7,8 resume one per cycle after release; none lost or duplicated.
- Padding discard / back-to-back messages: 0x83F00000 then 0x83F00000 → exactly 0,4,7,8,0,4,7,8. Padding zeros never emitted as E.
- Starved input: rdy=0 for 20 cycles → pop and push stay 0; raising rdy gives pop the next cycle.
- Reset mid-operation: assert reset during DECODE of the straddle test → pop/push go 0 asynchronously. After release, 0x83F00000 decodes cleanly to 0,4,7,8.
